// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift-register link blocks (transmitter and receivers).
package serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  // Bit-counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/piso_shift_reg.sv
// Loadable WIDTH-bit shift register; nxt is the bit that follows the current head in send order.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             dir_msb,
  input  logic [WIDTH-1:0] d,
  output logic             nxt
);
  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sr <= '0;
    else if (load)  sr <= d;
    else if (shift) sr <= dir_msb ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
  end

  // The head bit is driven onto q at load time, so the datapath always needs the second one.
  assign nxt = dir_msb ? sr[WIDTH-2] : sr[1];
endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load, frame/last strobes and optional idle gap.
module piso_tx
  import serial_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             frame,
  output logic             last,
  output logic             busy
);
  localparam int             CW    = cnt_width(WIDTH);
  localparam logic [CW-1:0]  TERM  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  PRE   = CW'(WIDTH - 2);
  localparam logic [3:0]     GINIT = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0]    gcnt;
  logic          xfer, at_term, nxt, first_bit;

  assign xfer      = load_valid && load_ready;
  assign at_term   = (state == SHIFT) && (cnt == TERM);
  assign first_bit = (MSB_FIRST != 0) ? d[WIDTH-1] : d[0];

  piso_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk     (clk),
    .rst     (rst),
    .load    (xfer),
    .shift   ((state == SHIFT) && !at_term),
    .dir_msb (MSB_FIRST != 0),
    .d       (d),
    .nxt     (nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (xfer) state_n = SHIFT;
      SHIFT:   if (at_term && !xfer) state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gcnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With no gap the last-bit cycle doubles as a load slot, giving gapless back-to-back words.
  always_comb begin
    load_ready = (state == IDLE) || (at_term && (GAP_CYCLES == 0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= IDLE_LEVEL;
      frame <= 1'b0;
      last  <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
      gcnt  <= '0;
    end else begin
      frame <= 1'b0;
      last  <= 1'b0;
      if (xfer) begin
        q     <= first_bit;
        frame <= 1'b1;
        busy  <= 1'b1;
        cnt   <= '0;
      end else begin
        unique case (state)
          SHIFT: begin
            if (!at_term) begin
              q    <= nxt;
              cnt  <= cnt + CW'(1);
              last <= (cnt == PRE);
            end else begin
              q    <= IDLE_LEVEL;
              gcnt <= GINIT;
              busy <= (GAP_CYCLES > 0);
            end
          end
          GAP: begin
            if (gcnt == '0) busy <= 1'b0;
            else            gcnt <= gcnt - 4'd1;
          end
          default: begin
            q    <= IDLE_LEVEL;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// Directed vector bench for piso_tx: MSB/LSB order, back-to-back, gap insertion, stall and async reset.
module tb_piso_tx;
  typedef struct packed {
    logic       lv;
    logic [7:0] d;
    logic       q, f, l, b, r;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv  = 1'b0;
  logic [7:0] d   = 8'h00;
  logic [2:0] q_o, fr_o, la_o, bu_o, rd_o;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  // 0: defaults (MSB first, no gap); 1: LSB first; 2: three gap cycles
  piso_tx u_a (.clk(clk), .rst(rst), .d(d), .load_valid(lv), .load_ready(rd_o[0]),
               .q(q_o[0]), .frame(fr_o[0]), .last(la_o[0]), .busy(bu_o[0]));
  piso_tx #(.MSB_FIRST(0)) u_l (.clk(clk), .rst(rst), .d(d), .load_valid(lv), .load_ready(rd_o[1]),
               .q(q_o[1]), .frame(fr_o[1]), .last(la_o[1]), .busy(bu_o[1]));
  piso_tx #(.GAP_CYCLES(3)) u_g (.clk(clk), .rst(rst), .d(d), .load_valid(lv), .load_ready(rd_o[2]),
               .q(q_o[2]), .frame(fr_o[2]), .last(la_o[2]), .busy(bu_o[2]));

  task automatic cmp(input string nm, input int cyc, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input logic l_v, input logic [7:0] dd,
                      input logic eq, input logic ef, input logic el, input logic eb, input logic er);
    vec_t v;
    v.lv = l_v; v.d = dd; v.q = eq; v.f = ef; v.l = el; v.b = eb; v.r = er;
    tbl.push_back(v);
  endtask

  // Each record: expected outputs during cycle i, then inputs presented for the edge ending it.
  task automatic run(input int sel, input string nm, input int c0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      cmp({nm, ".q"},     c0 + i, q_o[sel],  tbl[i].q);
      cmp({nm, ".frame"}, c0 + i, fr_o[sel], tbl[i].f);
      cmp({nm, ".last"},  c0 + i, la_o[sel], tbl[i].l);
      cmp({nm, ".busy"},  c0 + i, bu_o[sel], tbl[i].b);
      cmp({nm, ".ready"}, c0 + i, rd_o[sel], tbl[i].r);
      lv = tbl[i].lv;
      d  = tbl[i].d;
    end
    tbl.delete();
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    lv  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic word(input logic [7:0] w, input bit msb);
    for (int k = 1; k <= 8; k++)
      push(1'b0, 8'h00, msb ? w[8-k] : w[k-1], k == 1, k == 8, 1'b1, k == 8);
    push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // basic MSB-first A5, including reset state at cycle 0
    push(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    word(8'hA5, 1'b1);
    run(0, "basic", 0);

    // LSB-first 01
    do_rst();
    push(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    word(8'h01, 1'b0);
    run(1, "lsb", 0);

    // back-to-back FF then 00, valid held with d changed mid-word
    do_rst();
    push(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) push(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    push(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(0, "b2b", 0);

    // gap of 3 with valid held: FF then stalled 81
    do_rst();
    push(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) push(1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b1, 8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) push(1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2, "gap", 0);

    // async reset in the middle of A5, then 3C loaded on the first edge after release
    do_rst();
    @(negedge clk);
    cmp("rst.ready0", 0, rd_o[0], 1'b1);
    lv = 1'b1;
    d  = 8'hA5;
    @(negedge clk);
    lv = 1'b0;
    repeat (3) @(negedge clk);
    cmp("rst.busy_pre", 4, bu_o[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    cmp("rst.q",     4, q_o[0],  1'b0);
    cmp("rst.frame", 4, fr_o[0], 1'b0);
    cmp("rst.last",  4, la_o[0], 1'b0);
    cmp("rst.busy",  4, bu_o[0], 1'b0);
    cmp("rst.busy_g",4, bu_o[2], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cmp("rst.ready", 5, rd_o[0], 1'b1);
    lv = 1'b1;
    d  = 8'h3C;
    word(8'h3C, 1'b1);
    run(0, "post_rst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
